// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - shares one memory-controller port between fetch, load, store and debug
// Optional debug port enabled by defining DBG_PORT_EN.
module mem_access_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                fetch_req_in,
  input  logic [ADDR_W-1:0]   fetch_addr_in,
  output logic [2*DATA_W-1:0] inst_out,
  output logic                inst_fetch_done_out,
  input  logic                load_req_in,
  input  logic                store_req_in,
  input  logic [ADDR_W-1:0]   data_addr_in,
  input  logic [DATA_W-1:0]   store_data_in,
  output logic [DATA_W-1:0]   load_data_out,
  output logic                data_read_done_out,
  input  logic                dbg_req_in,
  input  logic                dbg_we_in,
  input  logic [ADDR_W-1:0]   dbg_addr_in,
  input  logic [DATA_W-1:0]   dbg_wdata_in,
  output logic [DATA_W-1:0]   dbg_rdata_out,
  output logic                dbg_done_out,
  output logic                mem_busy_out,
  output logic                mc_cmd_valid_out,
  input  logic                mc_cmd_ready_in,
  output logic                mc_cmd_we_out,
  output logic [ADDR_W-1:0]   mc_cmd_addr_out,
  output logic [DATA_W-1:0]   mc_cmd_wdata_out,
  input  logic                mc_rsp_valid_in,
  input  logic [DATA_W-1:0]   mc_rsp_data_in
);
  typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;
  typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE, OWN_DBG} owner_t;

  state_t            state;
  owner_t            owner;
  logic              fetch_hi;
  logic [DATA_W-1:0] inst_lo;
  logic              pend_fetch, pend_load, pend_store;
  logic [ADDR_W-1:0] fetch_addr_q, load_addr_q, store_addr_q;
  logic [DATA_W-1:0] store_data_q;
  logic              active;

  // A completed store has nothing left to report, so it stops counting as busy in DONE.
  assign active = (state != IDLE) && !(state == DONE && owner == OWN_STORE);

`ifdef DBG_PORT_EN
  logic              pend_dbg, dbg_we_q;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [DATA_W-1:0] dbg_wdata_q;
  assign mem_busy_out = pend_fetch | pend_load | pend_store | pend_dbg | active;
`else
  logic unused_dbg;
  assign unused_dbg    = ^{dbg_req_in, dbg_we_in, dbg_addr_in, dbg_wdata_in};
  assign dbg_rdata_out = '0;
  assign dbg_done_out  = 1'b0;
  assign mem_busy_out  = pend_fetch | pend_load | pend_store | active;
`endif

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state               <= IDLE;
      owner               <= OWN_FETCH;
      fetch_hi            <= 1'b0;
      inst_lo             <= '0;
      pend_fetch          <= 1'b0;
      pend_load           <= 1'b0;
      pend_store          <= 1'b0;
      fetch_addr_q        <= '0;
      load_addr_q         <= '0;
      store_addr_q        <= '0;
      store_data_q        <= '0;
      inst_out            <= '0;
      inst_fetch_done_out <= 1'b0;
      load_data_out       <= '0;
      data_read_done_out  <= 1'b0;
      mc_cmd_valid_out    <= 1'b0;
      mc_cmd_we_out       <= 1'b0;
      mc_cmd_addr_out     <= '0;
      mc_cmd_wdata_out    <= '0;
`ifdef DBG_PORT_EN
      pend_dbg            <= 1'b0;
      dbg_we_q            <= 1'b0;
      dbg_addr_q          <= '0;
      dbg_wdata_q         <= '0;
      dbg_rdata_out       <= '0;
      dbg_done_out        <= 1'b0;
`endif
    end else begin
      inst_fetch_done_out <= 1'b0;
      data_read_done_out  <= 1'b0;
`ifdef DBG_PORT_EN
      dbg_done_out        <= 1'b0;
      if (dbg_req_in && !pend_dbg) begin
        pend_dbg    <= 1'b1;
        dbg_we_q    <= dbg_we_in;
        dbg_addr_q  <= dbg_addr_in;
        dbg_wdata_q <= dbg_wdata_in;
      end
`endif
      // First request into a slot wins; later strobes to a pending slot are dropped.
      if (fetch_req_in && !pend_fetch) begin
        pend_fetch   <= 1'b1;
        fetch_addr_q <= fetch_addr_in;
      end
      if (load_req_in && !pend_load) begin
        pend_load   <= 1'b1;
        load_addr_q <= data_addr_in;
      end
      if (store_req_in && !pend_store) begin
        pend_store   <= 1'b1;
        store_addr_q <= data_addr_in;
        store_data_q <= store_data_in;
      end

      case (state)
        IDLE: begin
`ifdef DBG_PORT_EN
          if (pend_dbg) begin
            pend_dbg         <= 1'b0;
            owner            <= OWN_DBG;
            mc_cmd_we_out    <= dbg_we_q;
            mc_cmd_addr_out  <= dbg_addr_q;
            mc_cmd_wdata_out <= dbg_wdata_q;
            mc_cmd_valid_out <= 1'b1;
            state            <= CMD;
          end else
`endif
          if (pend_store) begin
            pend_store       <= 1'b0;
            owner            <= OWN_STORE;
            mc_cmd_we_out    <= 1'b1;
            mc_cmd_addr_out  <= store_addr_q;
            mc_cmd_wdata_out <= store_data_q;
            mc_cmd_valid_out <= 1'b1;
            state            <= CMD;
          end else if (pend_load) begin
            pend_load        <= 1'b0;
            owner            <= OWN_LOAD;
            mc_cmd_we_out    <= 1'b0;
            mc_cmd_addr_out  <= load_addr_q;
            mc_cmd_valid_out <= 1'b1;
            state            <= CMD;
          end else if (pend_fetch) begin
            pend_fetch       <= 1'b0;
            owner            <= OWN_FETCH;
            fetch_hi         <= 1'b0;
            mc_cmd_we_out    <= 1'b0;
            mc_cmd_addr_out  <= fetch_addr_q;
            mc_cmd_valid_out <= 1'b1;
            state            <= CMD;
          end
        end
        CMD: begin
          if (mc_cmd_ready_in) begin
            mc_cmd_valid_out <= 1'b0;
            if (mc_cmd_we_out) begin
              state <= DONE;
`ifdef DBG_PORT_EN
              if (owner == OWN_DBG) dbg_done_out <= 1'b1;
`endif
            end else begin
              state <= RSP;
            end
          end
        end
        RSP: begin
          if (mc_rsp_valid_in) begin
            if (owner == OWN_FETCH && !fetch_hi) begin
              // Low instruction byte in hand; go back for the next address (wraps at the top).
              inst_lo          <= mc_rsp_data_in;
              fetch_hi         <= 1'b1;
              mc_cmd_addr_out  <= mc_cmd_addr_out + ADDR_W'(1);
              mc_cmd_valid_out <= 1'b1;
              state            <= CMD;
            end else begin
              state <= DONE;
              case (owner)
                OWN_FETCH: begin
                  inst_out            <= {mc_rsp_data_in, inst_lo};
                  inst_fetch_done_out <= 1'b1;
                end
                OWN_LOAD: begin
                  load_data_out      <= mc_rsp_data_in;
                  data_read_done_out <= 1'b1;
                end
`ifdef DBG_PORT_EN
                OWN_DBG: begin
                  dbg_rdata_out <= mc_rsp_data_in;
                  dbg_done_out  <= 1'b1;
                end
`endif
                default: ;
              endcase
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed self-checking bench for mem_access_arbiter
// Debug-port expectations follow DBG_PORT_EN.
module tb_mem_access_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_req, load_req, store_req, dbg_req, dbg_we;
  logic [15:0] fetch_addr, data_addr, dbg_addr;
  logic [7:0]  store_data, dbg_wdata;
  logic [15:0] inst;
  logic        inst_done, load_done, dbg_done, busy;
  logic [7:0]  load_data, dbg_rdata;
  logic        cmd_valid, cmd_ready, cmd_we, rsp_valid;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata, rsp_data;

  logic [7:0]  mem [0:65535];
  logic [15:0] log_addr [$];
  int n_checks = 0, n_errors = 0;
  int n_fetch_done = 0, n_load_done = 0, n_dbg_done = 0;
  int lat, snap;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk_in(clk), .reset_n_in(reset_n),
    .fetch_req_in(fetch_req), .fetch_addr_in(fetch_addr),
    .inst_out(inst), .inst_fetch_done_out(inst_done),
    .load_req_in(load_req), .store_req_in(store_req),
    .data_addr_in(data_addr), .store_data_in(store_data),
    .load_data_out(load_data), .data_read_done_out(load_done),
    .dbg_req_in(dbg_req), .dbg_we_in(dbg_we), .dbg_addr_in(dbg_addr),
    .dbg_wdata_in(dbg_wdata), .dbg_rdata_out(dbg_rdata), .dbg_done_out(dbg_done),
    .mem_busy_out(busy),
    .mc_cmd_valid_out(cmd_valid), .mc_cmd_ready_in(cmd_ready), .mc_cmd_we_out(cmd_we),
    .mc_cmd_addr_out(cmd_addr), .mc_cmd_wdata_out(cmd_wdata),
    .mc_rsp_valid_in(rsp_valid), .mc_rsp_data_in(rsp_data)
  );

  // Memory-controller model: accepts on valid&ready, answers reads in the following cycle.
  always @(posedge clk) begin
    logic        acc, we;
    logic [15:0] a;
    logic [7:0]  wd;
    acc = reset_n && cmd_valid && cmd_ready;
    we  = cmd_we;
    a   = cmd_addr;
    wd  = cmd_wdata;
    #1;
    if (acc) begin
      log_addr.push_back(a);
      if (we) mem[a] = wd;
    end
    rsp_valid = acc && !we;
    rsp_data  = (acc && !we) ? mem[a] : 8'h00;
  end

  always @(negedge clk) begin
    if (inst_done) n_fetch_done++;
    if (load_done) n_load_done++;
    if (dbg_done)  n_dbg_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int which);
    case (which)
      0:       return inst_done;
      1:       return load_done;
      default: return dbg_done;
    endcase
  endfunction

  // Called on the negedge where strobes were raised; returns cycles until the done pulse.
  task automatic wait_done(input int which, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      fetch_req = 0; load_req = 0; store_req = 0; dbg_req = 0;
    end while (!done_of(which) && cycles < 40);
  endtask

  initial begin
    reset_n = 0; fetch_req = 0; load_req = 0; store_req = 0; dbg_req = 0; dbg_we = 0;
    fetch_addr = 0; data_addr = 0; dbg_addr = 0; store_data = 0; dbg_wdata = 0;
    cmd_ready = 1; rsp_valid = 0; rsp_data = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    mem[16'h0300] = 8'h5A; mem[16'h0400] = 8'hC3;
    mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;

    repeat (2) @(negedge clk);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_load_data", load_data, 8'h00);
    chk("rst_dbg_rdata", dbg_rdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_dones", {inst_done, load_done, dbg_done}, 3'b000);
    reset_n = 1;
    @(negedge clk);

    // Fetch from 0x0010
    log_addr.delete();
    snap = n_fetch_done;
    fetch_addr = 16'h0010; fetch_req = 1;
    wait_done(0, lat);
    chk("fetch_latency", lat, 6);
    chk("fetch_inst", inst, 16'h1234);
    chk("fetch_ncmd", log_addr.size(), 2);
    chk("fetch_cmd0", log_addr[0], 16'h0010);
    chk("fetch_cmd1", log_addr[1], 16'h0011);
    repeat (3) @(negedge clk);
    chk("fetch_one_pulse", n_fetch_done - snap, 1);
    chk("fetch_idle_busy", busy, 1'b0);

    // Store held off by ready
    log_addr.delete();
    cmd_ready = 0; data_addr = 16'h0200; store_data = 8'hA5; store_req = 1;
    @(negedge clk); store_req = 0;
    chk("store_busy_after_strobe", busy, 1'b1);
    chk("store_valid_not_yet", cmd_valid, 1'b0);
    @(negedge clk);
    chk("store_cmd", {cmd_valid, cmd_we, cmd_addr, cmd_wdata}, {1'b1, 1'b1, 16'h0200, 8'hA5});
    @(negedge clk);
    chk("store_hold1", {cmd_valid, cmd_addr}, {1'b1, 16'h0200});
    @(negedge clk);
    chk("store_hold2", {cmd_valid, cmd_addr}, {1'b1, 16'h0200});
    cmd_ready = 1;
    @(negedge clk);
    chk("store_valid_drop", cmd_valid, 1'b0);
    chk("store_busy_drop", busy, 1'b0);
    chk("store_mem", mem[16'h0200], 8'hA5);
    chk("store_ncmd", log_addr.size(), 1);
    repeat (2) @(negedge clk);

    // Load and debug read in the same cycle
    log_addr.delete();
    snap = n_dbg_done;
    data_addr = 16'h0300; load_req = 1;
    dbg_addr = 16'h0400; dbg_we = 0; dbg_req = 1;
    wait_done(1, lat);
    chk("ld_data", load_data, 8'h5A);
`ifdef DBG_PORT_EN
    chk("ld_latency_behind_dbg", lat, 8);
    chk("ld_ncmd", log_addr.size(), 2);
    chk("ld_first_cmd_dbg", log_addr[0], 16'h0400);
    chk("ld_second_cmd_load", log_addr[1], 16'h0300);
    chk("dbg_rdata", dbg_rdata, 8'hC3);
    chk("dbg_read_pulses", n_dbg_done - snap, 1);
`else
    chk("ld_latency", lat, 4);
    chk("ld_ncmd", log_addr.size(), 1);
    chk("ld_cmd_addr", log_addr[0], 16'h0300);
    chk("dbg_rdata_zero", dbg_rdata, 8'h00);
    chk("dbg_read_no_pulse", n_dbg_done - snap, 0);
`endif
    repeat (3) @(negedge clk);
    chk("ld_busy_idle", busy, 1'b0);

    // Debug write alone
    log_addr.delete();
    snap = n_dbg_done;
    dbg_addr = 16'h0500; dbg_wdata = 8'h11; dbg_we = 1; dbg_req = 1;
    @(negedge clk); dbg_req = 0; dbg_we = 0;
    repeat (8) @(negedge clk);
`ifdef DBG_PORT_EN
    chk("dbgw_ncmd", log_addr.size(), 1);
    chk("dbgw_mem", mem[16'h0500], 8'h11);
    chk("dbgw_pulses", n_dbg_done - snap, 1);
`else
    chk("dbgw_no_cmd", log_addr.size(), 0);
    chk("dbgw_mem_untouched", mem[16'h0500], 8'h00);
    chk("dbgw_no_pulse", n_dbg_done - snap, 0);
`endif
    chk("dbgw_busy_idle", busy, 1'b0);

    // Fetch wrapping at the top of memory
    log_addr.delete();
    fetch_addr = 16'hFFFF; fetch_req = 1;
    wait_done(0, lat);
    chk("wrap_latency", lat, 6);
    chk("wrap_cmd0", log_addr[0], 16'hFFFF);
    chk("wrap_cmd1", log_addr[1], 16'h0000);
    chk("wrap_inst", inst, 16'h5678);
    repeat (2) @(negedge clk);

    // Reset while the first fetch byte is being returned
    snap = n_fetch_done;
    fetch_addr = 16'h0010; fetch_req = 1;
    @(negedge clk); fetch_req = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 0;
    #1;
    chk("abort_valid", cmd_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_inst_cleared", inst, 16'h0000);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", n_fetch_done - snap, 0);
    chk("abort_busy_after", busy, 1'b0);
    fetch_req = 1;
    wait_done(0, lat);
    chk("refetch_latency", lat, 6);
    chk("refetch_inst", inst, 16'h1234);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
